// File: rtl/stack_engine.sv
// stack_engine: single-cycle LIFO with PUSH/POP/DUP/SWAP/REPLACE/OVER/CLEAR.
// Storage is unreset and read combinationally. Reads are masked by depth, so
// stale slots never reach the outputs. Illegal ops set a sticky error flag,
// and only reset or CLEAR drops that flag.
module stack_engine #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_op_valid,
  input  logic [2:0]                   i_mode,
  input  logic [WIDTH-1:0]             i_in_word,
  output logic [WIDTH-1:0]             o_top_word,
  output logic [WIDTH-1:0]             o_second_word,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_DUP     = 3'b011;
  localparam logic [2:0] OP_SWAP    = 3'b100;
  localparam logic [2:0] OP_REPLACE = 3'b101;
  localparam logic [2:0] OP_OVER    = 3'b110;
  localparam logic [2:0] OP_CLEAR   = 3'b111;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_err;
  logic             r_run;

  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_sec_idx;
  logic [AW-1:0]    w_push_idx;
  logic             w_has1;
  logic             w_has2;
  logic             w_not_full;
  logic [WIDTH-1:0] w_top_raw;
  logic [WIDTH-1:0] w_sec_raw;
  logic             w_act;

  logic             w_legal;
  logic             w_clear;
  logic [DW-1:0]    w_depth_nxt;
  logic             w_wr_a_en;
  logic [AW-1:0]    w_wr_a_idx;
  logic [WIDTH-1:0] w_wr_a_data;
  logic             w_wr_b_en;
  logic [AW-1:0]    w_wr_b_idx;
  logic [WIDTH-1:0] w_wr_b_data;

  // Slot addresses derived from the current depth; only used when in range.
  assign w_top_idx  = AW'(r_depth - DW'(1));
  assign w_sec_idx  = AW'(r_depth - DW'(2));
  assign w_push_idx = AW'(r_depth);

  assign w_has1     = (r_depth != '0);
  assign w_has2     = (r_depth >= DW'(2));
  assign w_not_full = (r_depth != DEPTH_C);

  assign w_top_raw  = r_mem[w_top_idx];
  assign w_sec_raw  = r_mem[w_sec_idx];

  // Ops are ignored until the reset release has passed through the sync flop.
  assign w_act = i_op_valid & r_run;

  // Decode the op into legality, next depth and up to two slot writes.
  always_comb begin
    w_legal     = 1'b1;
    w_clear     = 1'b0;
    w_depth_nxt = r_depth;
    w_wr_a_en   = 1'b0;
    w_wr_a_idx  = w_top_idx;
    w_wr_a_data = w_top_raw;
    w_wr_b_en   = 1'b0;
    w_wr_b_idx  = w_sec_idx;
    w_wr_b_data = w_sec_raw;
    case (i_mode)
      OP_NOP: begin
        w_legal = 1'b1;
      end
      OP_PUSH: begin
        if (w_not_full) begin
          w_wr_a_en   = 1'b1;
          w_wr_a_idx  = w_push_idx;
          w_wr_a_data = i_in_word;
          w_depth_nxt = r_depth + DW'(1);
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_POP: begin
        if (w_has1) begin
          w_depth_nxt = r_depth - DW'(1);
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_DUP: begin
        if (w_has1 && w_not_full) begin
          w_wr_a_en   = 1'b1;
          w_wr_a_idx  = w_push_idx;
          w_wr_a_data = w_top_raw;
          w_depth_nxt = r_depth + DW'(1);
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_SWAP: begin
        if (w_has2) begin
          w_wr_a_en   = 1'b1;
          w_wr_a_idx  = w_top_idx;
          w_wr_a_data = w_sec_raw;
          w_wr_b_en   = 1'b1;
          w_wr_b_idx  = w_sec_idx;
          w_wr_b_data = w_top_raw;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_REPLACE: begin
        if (w_has1) begin
          w_wr_a_en   = 1'b1;
          w_wr_a_idx  = w_top_idx;
          w_wr_a_data = i_in_word;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_OVER: begin
        if (w_has2 && w_not_full) begin
          w_wr_a_en   = 1'b1;
          w_wr_a_idx  = w_push_idx;
          w_wr_a_data = w_sec_raw;
          w_depth_nxt = r_depth + DW'(1);
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_CLEAR: begin
        w_clear     = 1'b1;
        w_depth_nxt = '0;
      end
      default: begin
        w_legal = 1'b1;
      end
    endcase
  end

  // Release flop: the first op is accepted on the second edge after reset rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Entry storage: no reset needed because reads are masked by depth.
  always_ff @(posedge i_clk) begin
    if (w_act && w_legal && w_wr_a_en) begin
      r_mem[w_wr_a_idx] <= w_wr_a_data;
    end
    if (w_act && w_legal && w_wr_b_en) begin
      r_mem[w_wr_b_idx] <= w_wr_b_data;
    end
  end

  // Depth and sticky error. Illegal ops freeze depth and raise err; CLEAR resets both.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (w_act) begin
      if (w_clear) begin
        r_depth <= '0;
        r_err   <= 1'b0;
      end else if (!w_legal) begin
        r_err   <= 1'b1;
      end else begin
        r_depth <= w_depth_nxt;
      end
    end
  end

  assign o_top_word    = w_has1 ? w_top_raw : '0;
  assign o_second_word = w_has2 ? w_sec_raw : '0;
  assign o_depth       = r_depth;
  assign o_empty       = (r_depth == '0);
  assign o_full        = (r_depth == DEPTH_C);
  assign o_err         = r_err;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine (WIDTH=4, DEPTH=4): directed scenarios plus random ops
// compared against a queue-based stack model.
module tb_stack_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [3:0] in_word = 4'h0;
  logic [3:0] top, second;
  logic [2:0] depth;
  logic       empty, full, err;

  int total = 0;
  int bad = 0;

  logic [3:0] m_stk[$];
  bit         m_err = 1'b0;

  stack_engine #(.WIDTH(4), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_valid(op_valid), .i_mode(mode),
    .i_in_word(in_word), .o_top_word(top), .o_second_word(second),
    .o_depth(depth), .o_empty(empty), .o_full(full), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 4'h0;
  endfunction

  function automatic logic [3:0] m_second();
    return (m_stk.size() > 1) ? m_stk[m_stk.size()-2] : 4'h0;
  endfunction

  task automatic model_apply(input bit v, input logic [2:0] md, input logic [3:0] w);
    int n;
    logic [3:0] t;
    n = m_stk.size();
    if (v) begin
      case (md)
        3'd1: if (n < 4) m_stk.push_back(w); else m_err = 1'b1;
        3'd2: if (n >= 1) void'(m_stk.pop_back()); else m_err = 1'b1;
        3'd3: if (n >= 1 && n < 4) m_stk.push_back(m_stk[n-1]); else m_err = 1'b1;
        3'd4: if (n >= 2) begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; end
              else m_err = 1'b1;
        3'd5: if (n >= 1) m_stk[n-1] = w; else m_err = 1'b1;
        3'd6: if (n >= 2 && n < 4) m_stk.push_back(m_stk[n-2]); else m_err = 1'b1;
        3'd7: begin m_stk.delete(); m_err = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // Drive one op at the negedge, let the posedge execute it, settle, update model.
  task automatic op(input bit v, input logic [2:0] md, input logic [3:0] w);
    @(negedge clk);
    op_valid = v; mode = md; in_word = w;
    @(posedge clk);
    #1;
    model_apply(v, md, w);
    op_valid = 1'b0; mode = 3'b000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_stk.delete(); m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    total++; if (depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0)
      begin bad++; $display("FAIL reset_flags got d=%0d e=%b f=%b err=%b exp d=0 e=1 f=0 err=0", depth, empty, full, err); end
    total++; if (top !== 4'h0 || second !== 4'h0)
      begin bad++; $display("FAIL reset_words got top=%h sec=%h exp 0/0", top, second); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    op_valid = 1'b1; mode = 3'd1; in_word = 4'h5;
    @(posedge clk); #1;
    total++; if (depth !== 3'd0)
      begin bad++; $display("FAIL reset_sync_first_edge got depth=%0d exp 0", depth); end
    @(posedge clk); #1;
    op_valid = 1'b0; mode = 3'd0;
    total++; if (depth !== 3'd1 || top !== 4'h5)
      begin bad++; $display("FAIL reset_sync_second_edge got d=%0d top=%h exp d=1 top=5", depth, top); end
  endtask

  task automatic test_push_basic();
    apply_reset();
    op(1'b1, 3'd1, 4'h3);
    op(1'b1, 3'd1, 4'h5);
    total++; if (top !== 4'h5 || second !== 4'h3 || depth !== 3'd2 || empty !== 1'b0 || err !== 1'b0)
      begin bad++; $display("FAIL push_basic got top=%h sec=%h d=%0d e=%b err=%b exp 5 3 2 0 0", top, second, depth, empty, err); end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    op(1'b1, 3'd1, 4'h1); op(1'b1, 3'd1, 4'h2); op(1'b1, 3'd1, 4'h3);
    total++; if (full !== 1'b0)
      begin bad++; $display("FAIL full_early got full=%b exp 0", full); end
    op(1'b1, 3'd1, 4'h4);
    total++; if (full !== 1'b1 || depth !== 3'd4)
      begin bad++; $display("FAIL full_set got full=%b d=%0d exp 1 4", full, depth); end
    op(1'b1, 3'd1, 4'h9);
    total++; if (top !== 4'h4 || depth !== 3'd4 || err !== 1'b1 || second !== 4'h3)
      begin bad++; $display("FAIL overflow got top=%h sec=%h d=%0d err=%b exp 4 3 4 1", top, second, depth, err); end
    op(1'b1, 3'd7, 4'h0);
    total++; if (depth !== 3'd0 || err !== 1'b0 || top !== 4'h0 || empty !== 1'b1)
      begin bad++; $display("FAIL clear got d=%0d err=%b top=%h e=%b exp 0 0 0 1", depth, err, top, empty); end
  endtask

  task automatic test_pop_empty();
    apply_reset();
    op(1'b1, 3'd2, 4'h0);
    total++; if (err !== 1'b1 || depth !== 3'd0 || top !== 4'h0)
      begin bad++; $display("FAIL pop_empty got err=%b d=%0d top=%h exp 1 0 0", err, depth, top); end
    op(1'b1, 3'd0, 4'h0); op(1'b1, 3'd0, 4'h0);
    total++; if (err !== 1'b1)
      begin bad++; $display("FAIL err_sticky got err=%b exp 1", err); end
    op(1'b1, 3'd1, 4'h8);
    op(1'b1, 3'd2, 4'h0);
    total++; if (empty !== 1'b1 || err !== 1'b1 || top !== 4'h0)
      begin bad++; $display("FAIL pop_to_empty got e=%b err=%b top=%h exp 1 1 0", empty, err, top); end
  endtask

  task automatic test_swap_over_replace();
    apply_reset();
    op(1'b1, 3'd1, 4'h7); op(1'b1, 3'd1, 4'h2);
    op(1'b1, 3'd4, 4'h0);
    total++; if (top !== 4'h7 || second !== 4'h2)
      begin bad++; $display("FAIL swap got top=%h sec=%h exp 7 2", top, second); end
    op(1'b1, 3'd6, 4'h0);
    total++; if (depth !== 3'd3 || top !== 4'h2 || second !== 4'h7)
      begin bad++; $display("FAIL over got d=%0d top=%h sec=%h exp 3 2 7", depth, top, second); end
    op(1'b1, 3'd5, 4'hA);
    total++; if (top !== 4'hA || second !== 4'h7 || err !== 1'b0)
      begin bad++; $display("FAIL replace got top=%h sec=%h err=%b exp A 7 0", top, second, err); end
    op(1'b1, 3'd3, 4'h0);
    total++; if (depth !== 3'd4 || top !== 4'hA || second !== 4'hA)
      begin bad++; $display("FAIL dup got d=%0d top=%h sec=%h exp 4 A A", depth, top, second); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    op(1'b1, 3'd1, 4'h1); op(1'b1, 3'd1, 4'h2); op(1'b1, 3'd1, 4'h3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (depth !== 3'd0 || top !== 4'h0 || second !== 4'h0 || empty !== 1'b1 || err !== 1'b0)
      begin bad++; $display("FAIL async_reset got d=%0d top=%h sec=%h e=%b err=%b exp 0 0 0 1 0", depth, top, second, empty, err); end
    m_stk.delete(); m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    op(1'b1, 3'd1, 4'h6);
    total++; if (top !== 4'h6 || second !== 4'h0 || depth !== 3'd1)
      begin bad++; $display("FAIL after_reset got top=%h sec=%h d=%0d exp 6 0 1", top, second, depth); end
  endtask

  task automatic test_op_valid_gate();
    apply_reset();
    op(1'b1, 3'd1, 4'hC);
    op(1'b1, 3'd2, 4'h0);
    op(1'b1, 3'd2, 4'h0);
    op(1'b1, 3'd1, 4'h4);
    for (int i = 0; i < 3; i++) op(1'b0, 3'd1, 4'hF);
    op(1'b0, 3'd7, 4'h0);
    total++; if (depth !== 3'd1 || top !== 4'h4 || err !== 1'b1)
      begin bad++; $display("FAIL op_valid_gate got d=%0d top=%h err=%b exp 1 4 1", depth, top, err); end
  endtask

  task automatic test_random();
    bit         v;
    logic [2:0] md;
    logic [3:0] w;
    int         errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      md = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      w  = 4'($urandom_range(0, 15));
      op(v, md, w);
      total++;
      if (top !== m_top() || second !== m_second() || depth !== 3'(m_stk.size()) ||
          empty !== (m_stk.size() == 0) || full !== (m_stk.size() == 4) || err !== m_err) begin
        bad++;
        if (errs < 10)
          $display("FAIL random[%0d] got top=%h sec=%h d=%0d e=%b f=%b err=%b exp %h %h %0d %b %b %b",
                   i, top, second, depth, empty, full, err, m_top(), m_second(), m_stk.size(),
                   m_stk.size() == 0, m_stk.size() == 4, m_err);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_full_overflow();
    test_pop_empty();
    test_swap_over_replace();
    test_async_reset();
    test_op_valid_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter WIDTH, default 4: bits per stack entry, valid range 1..32.
REQ-002 Parameter DEPTH, default 8: maximum number of entries, valid range 2..64.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 op_valid  input  1: qualifies mode; when 0 the cycle is a NOP.
REQ-006 mode  input  3: operation code, per REQ-012.
REQ-007 in_word  input  WIDTH: operand for PUSH and REPLACE.
REQ-008 top_word  output  WIDTH: entry at stack top; 0 when depth=0.
REQ-009 second_word  output  WIDTH: entry below top; 0 when depth<2.
REQ-010 depth  output  $clog2(DEPTH+1): current entry count, 0..DEPTH.
REQ-011 empty / full / err  outputs  1 each: empty=(depth==0); full=(depth==DEPTH); err=sticky illegal-op flag.

Function
REQ-012 mode encoding SHALL be:
- 000 NOP
- 001 PUSH in_word
- 010 POP
- 011 DUP (push copy of top)
- 100 SWAP top/second
- 101 REPLACE top with in_word
- 110 OVER (push copy of second)
- 111 CLEAR
REQ-013 Every legal op SHALL complete in one cycle; outputs reflect the new state after the same rising edge (registered storage, combinational read of top/second).
REQ-014 Legality preconditions SHALL be:
- PUSH: depth<DEPTH
- POP, REPLACE: depth>=1
- DUP: 1<=depth<DEPTH
- SWAP: depth>=2
- OVER: 2<=depth<DEPTH
- NOP, CLEAR: always legal
REQ-015 An illegal op SHALL leave all entries and depth unchanged and set err on that edge.
REQ-016 err SHALL remain 1 until reset or a CLEAR op; CLEAR SHALL set depth=0 and err=0 in one cycle.
REQ-017 Stale storage SHALL never be visible: top_word/second_word SHALL read 0 for slots at or above depth, regardless of memory contents.
REQ-018 A PUSH to depth DEPTH-1 SHALL assert full on the following cycle; a POP from depth 1 SHALL assert empty on the following cycle.
REQ-019 SWAP SHALL exchange exactly the two top entries; entries below SHALL be unchanged.
REQ-020 Entry values SHALL be stored exactly WIDTH bits; in_word bits are taken unmodified, with no arithmetic or truncation.
REQ-021 op_valid=0 SHALL override mode; no state change and no err update.
REQ-022 With WIDTH=4 and DEPTH=2, behaviour SHALL equal a two-entry stack register with the same mode semantics.

Reset
REQ-023 While rst=0: depth=0, empty=1, full=0, err=0, top_word=0, second_word=0, independent of clk.
REQ-024 Storage array SHALL NOT require reset; REQ-017 guarantees zeroed outputs.
REQ-025 Reset asserted mid-sequence SHALL discard all entries immediately; the first op after rst deassertion executes from the empty state.
REQ-026 Deassertion SHALL be synchronised so the first accepted op is on the second rising clk edge after rst rises.

Verification (WIDTH=4, DEPTH=4 unless noted)
REQ-027 Reset, then PUSH 3, PUSH 5 -> top=5, second=3, depth=2, empty=0, err=0.
REQ-028 PUSH 1,2,3,4 then PUSH 9 -> full=1 after 4th push; 5th leaves top=4, depth=4, err=1; CLEAR -> depth=0, err=0, top=0.
REQ-029 POP on empty -> err=1, depth=0, top=0; NOP cycles keep err=1.
REQ-030 PUSH 7, PUSH 2, SWAP, OVER, REPLACE 0xA -> after SWAP top=7/second=2; after OVER depth=3, top=2; after REPLACE top=0xA, second=7.
REQ-031 PUSH 1,2,3, drive rst=0 between clk edges -> outputs zero immediately; rst=1, wait one edge, then PUSH 6 -> top=6, second=0, depth=1.
REQ-032 op_valid=0 with mode=PUSH and in_word=0xF for 3 cycles -> depth, top and err unchanged.
